// File: rtl/id_ex_latch.sv
// id_ex_latch: ID/EX pipeline register of the 5-stage MIPS datapath.
// Captures WB/M/EX control and ID-stage operands each rising edge and
// presents them to EX one cycle later. Supports stall (hold), flush
// (bubble insertion) and a saturating count of inserted bubbles.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   stall, flush      hold all registers / load a NOP bubble (flush wins)
//   valid_in          ID stage holds a real instruction
//   ctlwb_in          {RegWrite, MemtoReg}
//   ctlm_in           {Branch, MemRead, MemWrite}
//   ctlex_in          {RegDst, ALUOp[1:0], ALUSrc}
//   npc_in, rdata1_in, rdata2_in, sign_ext_in   DATA_W operands
//   instr_2016_in, instr_1511_in                rt / rd fields
//   wb_ctlout, m_ctlout, regdst, aluop, alusrc  registered control
//   npcout, rdata1out, rdata2out, s_extendout   registered data
//   instrout_2016, instrout_1511                registered fields
//   valid_out         EX stage holds a real instruction
//   bubble_cnt        bubbles inserted since reset (saturating)
module id_ex_latch #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              valid_in,
  input  logic [1:0]        ctlwb_in,
  input  logic [2:0]        ctlm_in,
  input  logic [3:0]        ctlex_in,
  input  logic [DATA_W-1:0] npc_in,
  input  logic [DATA_W-1:0] rdata1_in,
  input  logic [DATA_W-1:0] rdata2_in,
  input  logic [DATA_W-1:0] sign_ext_in,
  input  logic [4:0]        instr_2016_in,
  input  logic [4:0]        instr_1511_in,
  output logic [1:0]        wb_ctlout,
  output logic [2:0]        m_ctlout,
  output logic              regdst,
  output logic [1:0]        aluop,
  output logic              alusrc,
  output logic [DATA_W-1:0] npcout,
  output logic [DATA_W-1:0] rdata1out,
  output logic [DATA_W-1:0] rdata2out,
  output logic [DATA_W-1:0] s_extendout,
  output logic [4:0]        instrout_2016,
  output logic [4:0]        instrout_1511,
  output logic              valid_out,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam int unsigned EX_W = 4;

  logic [EX_W-1:0] ex_q;
  logic            load_c;
  logic            bubble_c;
  logic            cnt_full_c;

  // Next-edge decisions: flush > stall > load
  always_comb begin
    load_c     = flush | ~stall;
    bubble_c   = flush | (~stall & ~valid_in);
    cnt_full_c = &bubble_cnt;
  end

  // Data and field registers: load on flush or normal load, hold on stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      npcout        <= '0;
      rdata1out     <= '0;
      rdata2out     <= '0;
      s_extendout   <= '0;
      instrout_2016 <= '0;
      instrout_1511 <= '0;
    end else if (load_c) begin
      npcout        <= npc_in;
      rdata1out     <= rdata1_in;
      rdata2out     <= rdata2_in;
      s_extendout   <= sign_ext_in;
      instrout_2016 <= instr_2016_in;
      instrout_1511 <= instr_1511_in;
    end
  end

  // Control and valid: a bubble (flush or invalid slot) loads NOP control
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_ctlout <= '0;
      m_ctlout  <= '0;
      ex_q      <= '0;
      valid_out <= 1'b0;
    end else if (load_c) begin
      if (bubble_c) begin
        wb_ctlout <= '0;
        m_ctlout  <= '0;
        ex_q      <= '0;
        valid_out <= 1'b0;
      end else begin
        wb_ctlout <= ctlwb_in;
        m_ctlout  <= ctlm_in;
        ex_q      <= ctlex_in;
        valid_out <= 1'b1;
      end
    end
  end

  // Saturating bubble counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt <= '0;
    end else if (bubble_c && !cnt_full_c) begin
      bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

  // EX control split into its named fields
  assign regdst = ex_q[3];
  assign aluop  = ex_q[2:1];
  assign alusrc = ex_q[0];

endmodule
